// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: initiator side of the Instruction_Memory read port.
// Owns the PC and issues one word address per cycle. Each returned word is
// tagged with its PC and buffered in a 2-entry FIFO that the decode stage
// drains with valid/ready. A branch/jump redirect flushes the FIFO and any
// read still in flight.
//
// Optional feature macro: MISALIGN_FAULT_EN
//   defined   : a misaligned redirect target raises fetch_fault and halts fetch
//               until an aligned redirect arrives (or rst).
//   undefined : redirect targets are truncated down to a word boundary and
//               fetch_fault is tied low.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   read_address   out  32  fetch address to Instruction_Memory (the PC)
//   inst           in   32  instruction word, returned the cycle after issue
//   redirect_valid in   1   branch/jump taken
//   redirect_pc    in   32  redirect target
//   id_ready       in   1   decode accepts the head entry this cycle
//   if_valid       out  1   head entry valid
//   if_inst        out  32  head entry instruction
//   if_pc          out  32  head entry PC
//   if_pc_plus4    out  32  head entry PC + 4 (mod 2^32)
//   fetch_fault    out  1   misaligned redirect trap
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] read_address,
   input  logic [31:0] inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        fetch_fault
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;
   localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

   // FIFO storage: the head entry lives directly in the output registers,
   // the second entry in the tail registers.
   logic [XLEN-1:0]  pc;
   logic             inflight;
   logic [XLEN-1:0]  inflight_pc;
   logic             tail_valid;
   logic [XLEN-1:0]  tail_inst;
   logic [XLEN-1:0]  tail_pc;
   logic             halted;

   logic             pop;
   logic             push;
   logic             issue;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] remain;
   logic [XLEN-1:0]  target;

   assign read_address = pc;

   // Handshake, occupancy and issue decision
   always_comb begin
      pop       = 1'b0;
      push      = 1'b0;
      issue     = 1'b0;
      count     = '0;
      occupancy = '0;
      remain    = '0;
      target    = '0;

      pop       = if_valid & id_ready;
      push      = inflight & ~redirect_valid;
      count     = CNT_W'(if_valid) + CNT_W'(tail_valid);
      occupancy = count + CNT_W'(inflight);
      remain    = count - CNT_W'(pop);
      // Issue only if the returning word is guaranteed a FIFO slot.
      issue     = !redirect_valid && !halted &&
                  ((occupancy < CNT_W'(FIFO_DEPTH)) || pop);
`ifdef MISALIGN_FAULT_EN
      target    = redirect_pc;
`else
      target    = redirect_pc & 32'hFFFF_FFFC;
`endif
   end

   // PC, in-flight tracking and the 2-entry FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         if_valid    <= 1'b0;
         if_inst     <= '0;
         if_pc       <= '0;
         if_pc_plus4 <= WORD_BYTES;
         tail_valid  <= 1'b0;
         tail_inst   <= '0;
         tail_pc     <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + WORD_BYTES;
         end

         if (redirect_valid) begin
            // Flush: the in-flight word is dropped because push is masked.
            pc         <= target;
            if_valid   <= 1'b0;
            tail_valid <= 1'b0;
         end else begin
            case (remain)
               2'd0: begin
                  if_valid   <= push;
                  tail_valid <= 1'b0;
                  if (push) begin
                     if_inst     <= inst;
                     if_pc       <= inflight_pc;
                     if_pc_plus4 <= inflight_pc + WORD_BYTES;
                  end
               end
               2'd1: begin
                  // One entry survives: promote the tail if the head was popped.
                  if (pop) begin
                     if_inst     <= tail_inst;
                     if_pc       <= tail_pc;
                     if_pc_plus4 <= tail_pc + WORD_BYTES;
                  end
                  tail_valid <= push;
                  if (push) begin
                     tail_inst <= inst;
                     tail_pc   <= inflight_pc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MISALIGN_FAULT_EN
   // Fault/halt state: set by a misaligned redirect, cleared by an aligned one.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_fault <= 1'b0;
         halted      <= 1'b0;
      end else if (redirect_valid) begin
         fetch_fault <= (redirect_pc[1:0] != 2'b00);
         halted      <= (redirect_pc[1:0] != 2'b00);
      end
   end
`else
   assign fetch_fault = 1'b0;
   assign halted      = 1'b0;
`endif

   // The issue rule makes a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && (remain == CNT_W'(FIFO_DEPTH))));

endmodule
